// File: rtl/lights_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lights_pkg
// Description : Light-head encodings and phase enumeration shared by the
//               intersection sequencer and its sub-blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package lights_pkg;

    localparam logic [1:0] GREEN  = 2'b00;
    localparam logic [1:0] YELLOW = 2'b01;
    localparam logic [1:0] RED    = 2'b10;

    typedef enum logic [2:0] {
        MAIN_GREEN  = 3'd0,
        MAIN_YELLOW = 3'd1,
        ALLRED_A    = 3'd2,
        SIDE_GREEN  = 3'd3,
        SIDE_YELLOW = 3'd4,
        ALLRED_B    = 3'd5
    } state_t;

endpackage
`default_nettype wire

// File: rtl/phase_timer.sv
`default_nettype none
// ============================================================================
// Module      : phase_timer
// Description : Loadable down-counter that saturates at zero; expired is high
//               while the count is zero.
// Revision    : 1.0 - initial release
// ============================================================================
module phase_timer #(
    parameter int               CNT_W     = 4,
    parameter logic [CNT_W-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             expired
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= RESET_VAL;
        end else if (load) begin
            r_count <= load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign expired = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/intersection_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : intersection_ctrl
// Description : Two-road intersection sequencer with all-red clearance and a
//               pedestrian walk request served during the side-road green.
// Revision    : 1.0 - initial release
// ============================================================================
module intersection_ctrl
    import lights_pkg::*;
#(
    parameter int T_GREEN_MAIN = 8,
    parameter int T_GREEN_SIDE = 6,
    parameter int T_YELLOW     = 3,
    parameter int T_ALLRED     = 2,
    parameter int CNT_W        = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       side_req,
    input  logic       ped_req,
    output logic [1:0] main_light,
    output logic [1:0] side_light,
    output logic       walk,
    output logic [2:0] phase
);

    localparam logic [CNT_W-1:0] c_ld_main_green = CNT_W'(T_GREEN_MAIN - 1);
    localparam logic [CNT_W-1:0] c_ld_side_green = CNT_W'(T_GREEN_SIDE - 1);
    localparam logic [CNT_W-1:0] c_ld_yellow     = CNT_W'(T_YELLOW - 1);
    localparam logic [CNT_W-1:0] c_ld_allred     = CNT_W'(T_ALLRED - 1);

    state_t           r_state;
    state_t           w_next;
    logic             w_expired;
    logic             w_load;
    logic [CNT_W-1:0] w_load_val;
    logic             w_serve;
    logic             r_ped_pending;
    logic             r_walk_phase;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= MAIN_GREEN;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            MAIN_GREEN:  if (w_expired && (side_req || r_ped_pending)) w_next = MAIN_YELLOW;
            MAIN_YELLOW: if (w_expired) w_next = ALLRED_A;
            ALLRED_A:    if (w_expired) w_next = SIDE_GREEN;
            SIDE_GREEN:  if (w_expired) w_next = SIDE_YELLOW;
            SIDE_YELLOW: if (w_expired) w_next = ALLRED_B;
            ALLRED_B:    if (w_expired) w_next = MAIN_GREEN;
            default:     w_next = ALLRED_B;
        endcase
    end

    // The timer reloads with the duration of whichever state is being entered.
    always_comb begin
        w_load_val = c_ld_allred;
        case (w_next)
            MAIN_GREEN:  w_load_val = c_ld_main_green;
            MAIN_YELLOW: w_load_val = c_ld_yellow;
            SIDE_GREEN:  w_load_val = c_ld_side_green;
            SIDE_YELLOW: w_load_val = c_ld_yellow;
            default:     w_load_val = c_ld_allred;
        endcase
    end

    assign w_load = (w_next != r_state);

    phase_timer #(
        .CNT_W     (CNT_W),
        .RESET_VAL (c_ld_main_green)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (w_load),
        .load_val (w_load_val),
        .expired  (w_expired)
    );

    assign w_serve = (r_state == ALLRED_A) && w_expired;

    // A request coinciding with the serve edge is honoured now, not deferred.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ped_pending <= 1'b0;
            r_walk_phase  <= 1'b0;
        end else if (w_serve) begin
            r_ped_pending <= 1'b0;
            r_walk_phase  <= r_ped_pending | ped_req;
        end else if (ped_req) begin
            r_ped_pending <= 1'b1;
        end
    end

    always_comb begin
        main_light = RED;
        side_light = RED;
        case (r_state)
            MAIN_GREEN:  main_light = GREEN;
            MAIN_YELLOW: main_light = YELLOW;
            SIDE_GREEN:  side_light = GREEN;
            SIDE_YELLOW: side_light = YELLOW;
            default: ;
        endcase
    end

    assign walk  = (r_state == SIDE_GREEN) && r_walk_phase;
    assign phase = r_state;

endmodule
`default_nettype wire

// File: tb/tb_intersection_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_intersection_ctrl
// Description : Scoreboard bench for intersection_ctrl with directed scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_intersection_ctrl;
    import lights_pkg::*;

    logic       clk      = 1'b0;
    logic       reset    = 1'b1;
    logic       side_req = 1'b0;
    logic       ped_req  = 1'b0;
    logic [1:0] main_light;
    logic [1:0] side_light;
    logic       walk;
    logic [2:0] phase;

    intersection_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .side_req   (side_req),
        .ped_req    (ped_req),
        .main_light (main_light),
        .side_light (side_light),
        .walk       (walk),
        .phase      (phase)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] ph;
        logic [1:0] ml;
        logic [1:0] sl;
        logic       w;
    } exp_t;

    exp_t  q[$];
    int    n_total = 0;
    int    n_bad   = 0;
    bit    chk_on  = 1'b0;
    string scn     = "init";

    function automatic exp_t mk(input logic [2:0] ph, input logic w);
        exp_t e;
        e.ph = ph;
        e.w  = w;
        e.ml = RED;
        e.sl = RED;
        case (ph)
            3'd0: e.ml = GREEN;
            3'd1: e.ml = YELLOW;
            3'd3: e.sl = GREEN;
            3'd4: e.sl = YELLOW;
            default: ;
        endcase
        return e;
    endfunction

    // Phase j cycles after entering MAIN_YELLOW: 3 yellow, 2 red, 6 green, 3 yellow, 2 red.
    function automatic logic [2:0] svc(input int j);
        if (j < 3)  return 3'd1;
        if (j < 5)  return 3'd2;
        if (j < 11) return 3'd3;
        if (j < 14) return 3'd4;
        return 3'd5;
    endfunction

    function automatic logic [2:0] exp_ph(input int k, input int s0, input int s1);
        if (s0 >= 0 && k >= s0 && k < s0 + 16) return svc(k - s0);
        if (s1 >= 0 && k >= s1 && k < s1 + 16) return svc(k - s1);
        return 3'd0;
    endfunction

    function automatic logic exp_w(input int k, input int s);
        return (s >= 0) && (k >= s + 5) && (k < s + 11);
    endfunction

    task automatic cyc(input logic sr, input logic pr, input logic rs, input exp_t e);
        @(posedge clk);
        #1;
        side_req = sr;
        ped_req  = pr;
        reset    = rs;
        q.push_back(e);
    endtask

    task automatic idle_reset(input string name);
        @(posedge clk);
        #1;
        scn      = name;
        reset    = 1'b1;
        side_req = 1'b0;
        ped_req  = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            n_total++;
            if ({phase, main_light, side_light, walk} !== e) begin
                n_bad++;
                $display("FAIL %s t=%0t: got phase=%0d main=%b side=%b walk=%b, want phase=%0d main=%b side=%b walk=%b",
                         scn, $time, phase, main_light, side_light, walk, e.ph, e.ml, e.sl, e.w);
            end
        end
        if (chk_on) begin
            n_total++;
            if (main_light != RED && side_light != RED) begin
                n_bad++;
                $display("FAIL safety t=%0t: main=%b side=%b, want at least one RED", $time, main_light, side_light);
            end
        end
    end

    initial begin
        idle_reset("idle");
        chk_on = 1'b1;
        for (int k = 0; k < 50; k++) cyc(1'b0, 1'b0, 1'b0, mk(3'd0, 1'b0));

        idle_reset("continuous");
        for (int k = 0; k < 48; k++) cyc(1'b1, 1'b0, 1'b0, mk(exp_ph(k, 8, 32), 1'b0));

        idle_reset("ped_pulse");
        for (int k = 0; k < 40; k++)
            cyc(1'b0, k == 3, 1'b0, mk(exp_ph(k, 8, -1), exp_w(k, 8)));

        idle_reset("ped_in_side_green");
        for (int k = 0; k < 64; k++)
            cyc(1'b0, (k == 3) || (k == 15), 1'b0,
                mk(exp_ph(k, 8, 32), exp_w(k, 8) || exp_w(k, 32)));

        idle_reset("reset_clears_pending");
        for (int k = 0; k < 44; k++)
            cyc(k < 13, k == 19, k == 20, (k <= 20) ? mk(exp_ph(k, 8, -1), 1'b0) : mk(3'd0, 1'b0));

        idle_reset("reset_restarts_green");
        for (int k = 0; k < 46; k++)
            cyc(1'b1, 1'b0, k == 20, (k <= 20) ? mk(exp_ph(k, 8, -1), 1'b0) : mk(exp_ph(k, 29, -1), 1'b0));

        idle_reset("late_demand");
        for (int k = 0; k < 36; k++) cyc(k == 12, 1'b0, 1'b0, mk(exp_ph(k, 13, -1), 1'b0));

        idle_reset("dropped_demand");
        for (int k = 0; k < 20; k++) cyc(k < 6, 1'b0, 1'b0, mk(3'd0, 1'b0));

        idle_reset("illegal_state");
        for (int k = 0; k < 10; k++) cyc(1'b0, 1'b0, 1'b0, mk(3'd0, 1'b0));
        @(posedge clk);
        #1;
        force dut.r_state = state_t'(3'd7);
        q.push_back(mk(3'd7, 1'b0));
        @(negedge clk);
        #1;
        release dut.r_state;
        cyc(1'b0, 1'b0, 1'b0, mk(3'd5, 1'b0));
        cyc(1'b0, 1'b0, 1'b0, mk(3'd5, 1'b0));
        for (int k = 0; k < 10; k++) cyc(1'b0, 1'b0, 1'b0, mk(3'd0, 1'b0));

        for (int i = 0; i < 4 && q.size() > 0; i++) @(negedge clk);
        #1;
        n_total++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
